// File: rtl/timer_controller.sv
// timer_controller: bus-mapped controller for one N-bit peripheral timer channel.
// Holds TCON/PERIOD/COUNT/PRESCALE, runs a prescaled up-count with rollover in
// periodic or one-shot mode, and drives a level interrupt from FLAG & IE.
module timer_controller #(
  parameter int N          = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_select,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [1:0]            size,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata,
  output logic                  rdata_valid,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_TCON     = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_PERIOD   = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(8'h18);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t                state;
  logic                  tcon_on;
  logic                  tcon_flag;
  logic                  tcon_oneshot;
  logic                  tcon_ie;
  logic [N-1:0]          period;
  logic [N-1:0]          count;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;

  logic [63:0] byte_mask;
  logic [63:0] tcon_ext, period_ext, count_ext, prescale_ext;
  logic [63:0] period_mrg, count_mrg, prescale_mrg;
  logic [63:0] rd_val;

  logic wr, rd;
  logic tcon_wr, period_wr, count_wr, prescale_wr;
  logic off_wr, tick, rollover, expire, leave_run;

  // Replace only the bytes covered by the access size; keep the rest.
  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                              input logic [63:0] wd,
                                              input logic [63:0] m);
    return (cur & ~m) | (wd & m);
  endfunction

  assign wr = chip_select & mem_write;
  // A simultaneous write wins; the read strobe is dropped.
  assign rd = chip_select & mem_read & ~mem_write;

  assign tcon_wr     = wr & (address == A_TCON);
  assign period_wr   = wr & (address == A_PERIOD);
  assign count_wr    = wr & (address == A_COUNT);
  assign prescale_wr = wr & (address == A_PRESCALE);

  // Prescaler tick and rollover; a COUNT write suppresses the tick entirely.
  assign off_wr    = tcon_wr & ~wdata[0];
  assign tick      = (state == S_RUN) && (pcnt == prescale);
  assign rollover  = tick & ~count_wr & (count >= period);
  assign expire    = rollover & tcon_oneshot & ~off_wr;
  assign leave_run = (state == S_RUN) & (off_wr | expire);

  assign irq = tcon_flag & tcon_ie;

  // Byte-enable mask derived from the access size.
  always_comb begin
    byte_mask = '1;
    case (size)
      2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
      2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
      default: byte_mask = '1;
    endcase
  end

  // Zero-extended register views and byte-merged write values.
  always_comb begin
    tcon_ext                     = '0;
    tcon_ext[3:0]                = {tcon_ie, tcon_oneshot, tcon_flag, tcon_on};
    period_ext                   = '0;
    period_ext[N-1:0]            = period;
    count_ext                    = '0;
    count_ext[N-1:0]             = count;
    prescale_ext                 = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale;
    period_mrg                   = merge_bytes(period_ext, wdata, byte_mask);
    count_mrg                    = merge_bytes(count_ext, wdata, byte_mask);
    prescale_mrg                 = merge_bytes(prescale_ext, wdata, byte_mask);
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_val = '0;
    case (address)
      A_TCON:     rd_val = tcon_ext;
      A_PERIOD:   rd_val = period_ext;
      A_COUNT:    rd_val = count_ext;
      A_PRESCALE: rd_val = prescale_ext;
      default:    rd_val = '0;
    endcase
  end

  // Mode FSM and TCON bits; hardware FLAG set beats W1C, ON=0 write beats expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tcon_on      <= 1'b0;
      tcon_flag    <= 1'b0;
      tcon_oneshot <= 1'b0;
      tcon_ie      <= 1'b0;
    end else begin
      if (rollover)
        tcon_flag <= 1'b1;
      else if (tcon_wr && wdata[1])
        tcon_flag <= 1'b0;
      if (tcon_wr) begin
        tcon_on      <= wdata[0];
        tcon_oneshot <= wdata[2];
        tcon_ie      <= wdata[3];
      end
      case (state)
        S_IDLE: begin
          if (tcon_wr && wdata[0]) state <= S_RUN;
        end
        S_RUN: begin
          if (off_wr) begin
            state <= S_IDLE;
          end else if (expire) begin
            state   <= S_EXPIRED;
            tcon_on <= 1'b0;
          end
        end
        S_EXPIRED: begin
          if (tcon_wr) state <= wdata[0] ? S_RUN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // COUNT and prescaler; a bus write to COUNT beats the tick and restarts pcnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      pcnt  <= '0;
    end else begin
      if (count_wr)
        count <= count_mrg[N-1:0];
      else if (rollover)
        count <= '0;
      else if (tick)
        count <= count + 1'b1;
      if (count_wr || state != S_RUN || leave_run || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;
    end
  end

  // PERIOD and PRESCALE byte-lane writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period   <= '1;
      prescale <= '0;
    end else begin
      if (period_wr)   period   <= period_mrg[N-1:0];
      if (prescale_wr) prescale <= prescale_mrg[PRESCALE_W-1:0];
    end
  end

  // Registered read data, masked to the access size; zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (rd) begin
      rdata       <= rd_val & byte_mask;
      rdata_valid <= 1'b1;
    end else begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: directed vectors with hand-computed expectations.
module tb_timer_controller;

  localparam logic [7:0] A_TCON     = 8'h00;
  localparam logic [7:0] A_PERIOD   = 8'h08;
  localparam logic [7:0] A_COUNT    = 8'h10;
  localparam logic [7:0] A_PRESCALE = 8'h18;
  localparam logic [7:0] A_UNMAP    = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        chip_select;
  logic [7:0]  address;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  int e2c[5] = '{0, 1, 2, 3, 0};
  int e2i[5] = '{0, 0, 0, 1, 1};
  int e3c[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  int e3i[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
  int e4c[3] = '{0, 1, 2};

  timer_controller #(.N(16), .ADDR_WIDTH(8), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .chip_select(chip_select), .address(address),
    .mem_write(mem_write), .mem_read(mem_read), .size(size), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [1:0] sz, input logic [63:0] d);
    chip_select = 1'b1; mem_write = 1'b1; address = a; size = sz; wdata = d;
    @(negedge clk);
    chip_select = 1'b0; mem_write = 1'b0; wdata = '0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [1:0] sz,
                          input logic [63:0] exp);
    chip_select = 1'b1; mem_read = 1'b1; address = a; size = sz;
    @(negedge clk);
    chip_select = 1'b0; mem_read = 1'b0;
    check({tag, "_vld"}, rdata_valid, 1'b1);
    check(tag, rdata, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; chip_select = 1'b0; address = '0; mem_write = 1'b0;
    mem_read = 1'b0; size = 2'b11; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 64'h0);
    check("rst_vld", rdata_valid, 1'b0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Reset values and byte-lane behaviour
    read_chk("rv_tcon", A_TCON, 2'b11, 64'h0);
    read_chk("rv_period", A_PERIOD, 2'b11, 64'hFFFF);
    read_chk("rv_count", A_COUNT, 2'b11, 64'h0);
    read_chk("rv_presc", A_PRESCALE, 2'b11, 64'h0);
    @(negedge clk);
    check("idle_vld", rdata_valid, 1'b0);
    check("idle_rdata", rdata, 64'h0);
    bus_write(A_PERIOD, 2'b01, 64'h1234);
    bus_write(A_PERIOD, 2'b00, 64'hFFFF_FFAB);
    read_chk("t6_period", A_PERIOD, 2'b01, 64'h12AB);
    bus_write(A_COUNT, 2'b01, 64'h01FF);
    read_chk("t6_count8", A_COUNT, 2'b00, 64'hFF);
    read_chk("t6_count64", A_COUNT, 2'b11, 64'h1FF);
    bus_write(A_PRESCALE, 2'b11, 64'h123);
    read_chk("presc_trunc", A_PRESCALE, 2'b11, 64'h23);
    bus_write(A_UNMAP, 2'b11, 64'hDEAD);
    read_chk("unmapped", A_UNMAP, 2'b11, 64'h0);
    chip_select = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    address = A_PRESCALE; size = 2'b00; wdata = 64'h05;
    @(negedge clk);
    chip_select = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wdata = '0;
    check("rw_vld", rdata_valid, 1'b0);
    read_chk("rw_presc", A_PRESCALE, 2'b00, 64'h05);
    do_reset();

    // Periodic, PERIOD=3, PRESCALE=0
    bus_write(A_PERIOD, 2'b01, 64'd3);
    bus_write(A_TCON, 2'b00, 64'h9);
    chip_select = 1'b1; mem_read = 1'b1; address = A_COUNT; size = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t2_cnt%0d", k), rdata, 64'(e2c[k]));
      check($sformatf("t2_irq%0d", k), irq, 64'(e2i[k]));
    end
    chip_select = 1'b0; mem_read = 1'b0;
    do_reset();

    // Prescaled, PRESCALE=2, PERIOD=1
    bus_write(A_PERIOD, 2'b01, 64'd1);
    bus_write(A_PRESCALE, 2'b00, 64'd2);
    bus_write(A_TCON, 2'b00, 64'h9);
    chip_select = 1'b1; mem_read = 1'b1; address = A_COUNT; size = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t3_cnt%0d", k), rdata, 64'(e3c[k]));
      check($sformatf("t3_irq%0d", k), irq, 64'(e3i[k]));
    end
    chip_select = 1'b0; mem_read = 1'b0;
    do_reset();

    // One-shot, PERIOD=2
    bus_write(A_PERIOD, 2'b01, 64'd2);
    bus_write(A_TCON, 2'b00, 64'h5);
    repeat (6) @(negedge clk);
    read_chk("t4_tcon", A_TCON, 2'b00, 64'h6);
    read_chk("t4_count", A_COUNT, 2'b11, 64'h0);
    check("t4_irq", irq, 1'b0);
    bus_write(A_TCON, 2'b00, 64'h5);
    chip_select = 1'b1; mem_read = 1'b1; address = A_COUNT; size = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_rerun%0d", k), rdata, 64'(e4c[k]));
    end
    chip_select = 1'b0; mem_read = 1'b0;
    read_chk("t4_tcon2", A_TCON, 2'b00, 64'h6);
    bus_write(A_TCON, 2'b00, 64'h0);
    read_chk("t4_idle", A_TCON, 2'b00, 64'h2);
    do_reset();

    // W1C collides with rollover: hardware set wins
    bus_write(A_PERIOD, 2'b01, 64'd3);
    bus_write(A_TCON, 2'b00, 64'h9);
    repeat (3) @(negedge clk);
    check("t5_irq_pre", irq, 1'b0);
    bus_write(A_TCON, 2'b00, 64'h2);
    read_chk("t5_flag", A_TCON, 2'b00, 64'h2);
    read_chk("t5_count", A_COUNT, 2'b11, 64'h0);
    bus_write(A_TCON, 2'b00, 64'h2);
    read_chk("t5_clr", A_TCON, 2'b00, 64'h0);
    do_reset();

    // Reset mid-RUN with FLAG set and a read in flight
    bus_write(A_PERIOD, 2'b01, 64'd0);
    bus_write(A_TCON, 2'b00, 64'h9);
    chip_select = 1'b1; mem_read = 1'b1; address = A_TCON; size = 2'b11;
    repeat (2) @(negedge clk);
    check("t1_pre_rd", rdata, 64'hB);
    check("t1_pre_irq", irq, 1'b1);
    rst = 1'b1;
    #1;
    check("t1_rdata", rdata, 64'h0);
    check("t1_vld", rdata_valid, 1'b0);
    check("t1_irq", irq, 1'b0);
    chip_select = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_chk("t1_tcon", A_TCON, 2'b11, 64'h0);
    read_chk("t1_period", A_PERIOD, 2'b11, 64'hFFFF);
    read_chk("t1_presc", A_PRESCALE, 2'b11, 64'h0);
    repeat (4) @(negedge clk);
    read_chk("t1_count", A_COUNT, 2'b11, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
